pipe_stage_chain: RTL and testbench

//  Parametrised chain of STAGES pipeline registers replacing the hand-written per-boundary

---
 rtl/pipe_stage_chain_if.sv | 44 ++++
 rtl/pipe_stage_chain.sv | 91 +++++++++
 tb/tb_pipe_stage_chain.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain_if
// Bus bundle for pipe_stage_chain: upstream fetch handshake, hazard-unit
// stall/flush vectors, per-slot forwarding taps and the oldest-slot output.
//
// Handshake: an entry is transferred into slot 0 on a rising edge where
// in_valid && in_ready. While in_ready is low the producer holds in_valid and
// in_data and the chain ignores them. The output side has no ready: when
// out_valid is high and the oldest slot is neither stalled nor flushed, the
// entry retires on that edge.
//
// Signals
//   in_valid, in_data   producer -> chain, slot-0 entry
//   in_ready            chain -> producer, low while slot 0 is frozen
//   stall_i, flush_i    hazard unit -> chain, one bit per slot
//   slot_valid          valid bit of every slot
//   slot_data           payload of every slot, slot k at [k*WIDTH +: WIDTH]
//   out_valid, out_data oldest slot (STAGES-1)
// Modports: master = producer/hazard side, slave = the chain itself.
// ---------------------------------------------------------------------------
interface pipe_stage_chain_if #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64
);
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic [STAGES-1:0]         stall_i;
    logic [STAGES-1:0]         flush_i;
    logic [STAGES-1:0]         slot_valid;
    logic [STAGES*WIDTH-1:0]   slot_data;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;

    modport master (
        output in_valid, in_data, stall_i, flush_i,
        input  in_ready, slot_valid, slot_data, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, stall_i, flush_i,
        output in_ready, slot_valid, slot_data, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
// Generic chain of STAGES pipeline registers (slot 0 youngest, slot STAGES-1
// oldest). Each slot holds a valid bit and a WIDTH-bit payload and follows
// per-slot stall/flush requests from the hazard unit. A stall on any slot
// freezes every younger slot; the first unstalled slot behind a frozen one
// takes a bubble. Invalid slots always carry a zero payload so forwarding
// taps are deterministic.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   bus         pipe_stage_chain_if.slave (handshake, stall/flush, taps)
//   retire_cnt  number of retired valid entries, wraps modulo 2^CNT_W
// Requires STAGES >= 2.
// ---------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_chain_if.slave    bus,
    output logic [CNT_W-1:0]     retire_cnt
);

    logic [STAGES-1:0]       valid_q;
    logic [STAGES*WIDTH-1:0] data_q;

    logic [STAGES-1:0]       eff_stall;
    logic [STAGES-1:0]       up_stall;
    logic [STAGES-1:0]       prev_valid;
    logic [STAGES*WIDTH-1:0] prev_data;
    logic                    retire;

    // A slot is frozen if it or any older slot requests a stall.
    always_comb begin
        eff_stall = '0;
        eff_stall[STAGES-1] = bus.stall_i[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            eff_stall[k] = eff_stall[k+1] | bus.stall_i[k];
        end
    end

    // View of each slot's upstream neighbour; slot 0's neighbour is the input.
    always_comb begin
        up_stall   = {eff_stall[STAGES-2:0], 1'b0};
        prev_valid = {valid_q[STAGES-2:0], bus.in_valid};
        prev_data  = {data_q[(STAGES-1)*WIDTH-1:0], bus.in_data};
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (rst || bus.flush_i[k]) begin
                // Flush wins over stall so a killed entry never lingers.
                valid_q[k]                <= 1'b0;
                data_q[k*WIDTH +: WIDTH]  <= '0;
            end else if (eff_stall[k]) begin
                valid_q[k]                <= valid_q[k];
                data_q[k*WIDTH +: WIDTH]  <= data_q[k*WIDTH +: WIDTH];
            end else if (up_stall[k]) begin
                // Upstream is frozen but this slot moves on: insert a bubble.
                valid_q[k]                <= 1'b0;
                data_q[k*WIDTH +: WIDTH]  <= '0;
            end else begin
                // Keep the zero-payload rule for invalid entries from the input.
                valid_q[k]                <= prev_valid[k];
                data_q[k*WIDTH +: WIDTH]  <= prev_valid[k] ? prev_data[k*WIDTH +: WIDTH] : '0;
            end
        end
    end

    // The oldest slot has no back-pressure except its own stall; WB always consumes.
    assign retire = valid_q[STAGES-1] & ~bus.stall_i[STAGES-1] & ~bus.flush_i[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready   = ~eff_stall[0];
    assign bus.slot_valid = valid_q;
    assign bus.slot_data  = data_q;
    assign bus.out_valid  = valid_q[STAGES-1];
    assign bus.out_data   = data_q[(STAGES-1)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
// Directed bench for pipe_stage_chain (STAGES=4, WIDTH=16, CNT_W=4).
// The driver pushes the hand-derived retiring payloads into exp_q when it
// issues them; a negedge monitor pops and compares on every retirement.
// Slot taps, in_ready and retire_cnt are checked directly by the driver.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;
    localparam int STAGES = 4;
    localparam int WIDTH  = 16;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] retire_cnt;

    logic [WIDTH-1:0] exp_q[$];
    int               checks;
    int               errors;

    pipe_stage_chain_if #(.STAGES(STAGES), .WIDTH(WIDTH)) bus ();

    pipe_stage_chain #(
        .STAGES (STAGES),
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .retire_cnt (retire_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input logic v, input logic [WIDTH-1:0] d,
                         input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.stall_i  = st;
        bus.flush_i  = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic [STAGES-1:0] st, input logic [STAGES-1:0] fl);
        apply(v, d, st, fl);
        tick();
    endtask

    // Issue one entry; push it as expected output only if it will retire.
    task automatic send(input logic [WIDTH-1:0] d, input bit will_retire);
        if (will_retire) exp_q.push_back(d);
        step(1'b1, d, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        apply(1'b0, '0, '0, '0);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic check_empty(input string name);
        check({name, "_valid"}, bus.slot_valid, '0);
        check({name, "_data"},  bus.slot_data,  '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && bus.out_valid && !bus.stall_i[STAGES-1] && !bus.flush_i[STAGES-1]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got=%0h expected=none at %0t", bus.out_data, $time);
            end else begin
                check("retire_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        apply(1'b0, '0, '0, '0);

        // Reset state
        do_reset(2);
        check_empty("reset");
        check("reset_retire_cnt", retire_cnt, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);

        // 1. Streaming 1..10
        for (int i = 1; i <= 10; i++) begin
            send(WIDTH'(i), 1'b1);
            if (i == 4) begin
                check("stream_first_valid", bus.out_valid, 1);
                check("stream_first_data", bus.out_data, 1);
            end
        end
        idle(4);
        check("stream_retire_cnt", retire_cnt, 10);
        check_empty("stream_drained");

        // 2. Backward stall on slot 2 for two cycles
        do_reset(1);
        for (int i = 11; i <= 14; i++) send(WIDTH'(i), 1'b1);
        for (int c = 0; c < 2; c++) begin
            apply(1'b1, 16'h00aa, 4'b0100, 4'b0000);
            #1;
            check("stall_in_ready", bus.in_ready, 0);
            tick();
            check("stall_out_valid", bus.out_valid, 0);
            check("stall_slot_valid", bus.slot_valid, 4'b0111);
            check("stall_slot_data", bus.slot_data, 64'h0000_000c_000d_000e);
        end
        check("stall_retire_mid", retire_cnt, 1);
        send(16'd15, 1'b1);
        send(16'd16, 1'b1);
        idle(5);
        check("stall_retire_cnt", retire_cnt, 6);

        // 3. Load-use stall on slot 0 with A,B,C,D in flight
        do_reset(1);
        send(16'h000a, 1'b1);
        send(16'h000b, 1'b1);
        send(16'h000c, 1'b1);
        send(16'h000d, 1'b1);
        step(1'b1, 16'h000e, 4'b0001, 4'b0000);
        check("loaduse_slot_valid", bus.slot_valid, 4'b1101);
        check("loaduse_slot_data", bus.slot_data, 64'h000b_000c_0000_000d);
        check("loaduse_retire", retire_cnt, 1);
        idle(5);
        check("loaduse_retire_cnt", retire_cnt, 4);

        // 4. Flush beats stall on slots 0-1
        do_reset(1);
        send(16'h0021, 1'b1);
        send(16'h0022, 1'b1);
        send(16'h0023, 1'b0);
        send(16'h0024, 1'b0);
        step(1'b1, 16'h0025, 4'b0010, 4'b0011);
        check("flushstall_slot_valid", bus.slot_valid, 4'b1000);
        check("flushstall_slot_data", bus.slot_data, 64'h0022_0000_0000_0000);
        idle(5);
        check("flushstall_retire_cnt", retire_cnt, 2);

        // 5. Exception flush of the whole pipe
        do_reset(1);
        send(16'h0031, 1'b0);
        send(16'h0032, 1'b0);
        send(16'h0033, 1'b0);
        send(16'h0034, 1'b0);
        step(1'b1, 16'h0035, 4'b0000, 4'b1111);
        check_empty("exception");
        check("exception_retire", retire_cnt, 0);
        idle(5);
        check("exception_retire_cnt", retire_cnt, 0);

        // 6. Counter wrap after 17 retirements, then reset with a full pipe
        do_reset(1);
        for (int i = 0; i < 17; i++) send(WIDTH'(16'h0041 + i), 1'b1);
        idle(5);
        check("wrap_retire_cnt", retire_cnt, 1);
        for (int i = 0; i < 4; i++) send(WIDTH'(16'h0061 + i), 1'b0);
        check("prereset_full", bus.slot_valid, 4'b1111);
        do_reset(1);
        check_empty("midreset");
        check("midreset_retire_cnt", retire_cnt, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        idle(2);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
